// File: rtl/traffic_light_monitor_if.sv
// Observation bus between a traffic light controller and its passive monitor.
// The monitor samples the lamps and the error clear, and reports phase, timing and sticky flags.
interface traffic_light_monitor_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CYC_W = 16
);
  logic [0:2]       leds;
  logic             err_clr;
  logic [1:0]       phase;
  logic             phase_done;
  logic [CNT_W-1:0] last_len;
  logic [CYC_W-1:0] cycles;
  logic [3:0]       err;

  modport master (
    output leds,
    output err_clr,
    input  phase,
    input  phase_done,
    input  last_len,
    input  cycles,
    input  err
  );

  modport slave (
    input  leds,
    input  err_clr,
    output phase,
    output phase_done,
    output last_len,
    output cycles,
    output err
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for a green->yellow->red lamp sequence: measures phase lengths,
// flags illegal patterns, ordering and timing violations, and counts completed cycles.
module traffic_light_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned GREEN_MIN  = 4,
  parameter int unsigned GREEN_MAX  = 80,
  parameter int unsigned YELLOW_MIN = 2,
  parameter int unsigned YELLOW_MAX = 16,
  parameter int unsigned RED_MIN    = 2,
  parameter int unsigned RED_MAX    = 16
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  traffic_light_monitor_if.slave   mon
);

  localparam logic [CNT_W-1:0] GMin = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMax = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YMin = CNT_W'(YELLOW_MIN);
  localparam logic [CNT_W-1:0] YMax = CNT_W'(YELLOW_MAX);
  localparam logic [CNT_W-1:0] RMin = CNT_W'(RED_MIN);
  localparam logic [CNT_W-1:0] RMax = CNT_W'(RED_MAX);

  typedef enum logic [2:0] {StDark, StGreen, StYellow, StRed, StBad} state_e;

  state_e           state_q, state_d, pat_st;
  logic [0:2]       leds_q, pat_q;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] lim_min, lim_max;
  logic [CNT_W-1:0] last_len_q;
  logic [CYC_W-1:0] cycles_q;
  logic [3:0]       err_q, err_set;
  logic             done_d, done_q, cyc_inc;
  logic             change, lit, legal;

  // pat_q is the pattern seen on the previous cycle; a difference marks a phase boundary.
  assign change = (leds_q != pat_q);
  assign lit    = (state_q == StGreen) || (state_q == StYellow) || (state_q == StRed);
  assign legal  = ((state_q == StDark)   && (pat_st == StGreen))  ||
                  ((state_q == StGreen)  && (pat_st == StYellow)) ||
                  ((state_q == StYellow) && (pat_st == StRed))    ||
                  ((state_q == StRed)    && (pat_st == StGreen));

  always_comb begin
    pat_st = StBad;
    unique case (leds_q)
      3'b000:  pat_st = StDark;
      3'b100:  pat_st = StGreen;
      3'b010:  pat_st = StYellow;
      3'b001:  pat_st = StRed;
      default: pat_st = StBad;
    endcase
  end

  always_comb begin
    lim_min = '0;
    lim_max = '0;
    unique case (state_q)
      StGreen:  begin lim_min = GMin; lim_max = GMax; end
      StYellow: begin lim_min = YMin; lim_max = YMax; end
      StRed:    begin lim_min = RMin; lim_max = RMax; end
      default:  begin lim_min = '0;   lim_max = '0;   end
    endcase
  end

  always_comb begin
    if (change)              dur_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (dur_q != '1)    dur_d = dur_q + 1'b1;
    else                     dur_d = dur_q;
  end

  // Next state plus the events that accompany each transition.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cyc_inc = 1'b0;
    err_set = '0;
    if (change) begin
      state_d = pat_st;
      if (lit && (dur_q < lim_min)) err_set[2] = 1'b1;
      if (pat_st == StBad) begin
        err_set[0] = 1'b1;
      end else if (state_q == StBad) begin
        // Resync: the first clean pattern is accepted unchecked.
        err_set = '0;
      end else if (pat_st == StDark) begin
        if (lit) err_set[1] = 1'b1;
      end else if (legal) begin
        done_d  = lit;
        cyc_inc = (state_q == StRed);
      end else begin
        err_set[1] = 1'b1;
      end
    end else if (lit && (dur_q == lim_max)) begin
      err_set[3] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      leds_q     <= '0;
      pat_q      <= '0;
      state_q    <= StDark;
      dur_q      <= '0;
      done_q     <= 1'b0;
      last_len_q <= '0;
      cycles_q   <= '0;
      err_q      <= '0;
    end else begin
      leds_q  <= mon.leds;
      pat_q   <= leds_q;
      state_q <= state_d;
      dur_q   <= dur_d;
      done_q  <= done_d;
      if (done_d) last_len_q <= dur_q;
      if (cyc_inc && (cycles_q != '1)) cycles_q <= cycles_q + 1'b1;
      err_q   <= (mon.err_clr ? 4'b0000 : err_q) | err_set;
    end
  end

  always_comb begin
    mon.phase = 2'd0;
    unique case (state_q)
      StGreen:  mon.phase = 2'd1;
      StYellow: mon.phase = 2'd2;
      StRed:    mon.phase = 2'd3;
      default:  mon.phase = 2'd0;
    endcase
    mon.phase_done = done_q;
    mon.last_len   = last_len_q;
    mon.cycles     = cycles_q;
    mon.err        = err_q;
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a table of lamp steps with expected
// results, then hand-written latency and reset sequences.
module tb_traffic_light_monitor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_cnt;
  logic [7:0] len_seen;

  traffic_light_monitor_if #(.CNT_W(8), .CYC_W(16)) bus ();

  traffic_light_monitor dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .mon    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  leds;
    int          hold;
    bit          clr;
    logic [1:0]  ph;
    int          done;
    logic [7:0]  len;
    logic [15:0] cyc;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive a pattern for n edges, sampling 1 time unit after each edge.
  task automatic step(input logic [2:0] leds, input int n, input bit clr);
    bus.leds    = leds;
    bus.err_clr = clr;
    done_cnt    = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.phase_done) begin
        done_cnt++;
        len_seen = bus.last_len;
      end
    end
    bus.err_clr = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    done_cnt    = 0;
    len_seen    = '0;
    rst_n       = 1'b0;
    bus.leds    = 3'b000;
    bus.err_clr = 1'b0;

    //            leds    hold clr  ph  done len    cyc    err
    vecs[0]  = '{3'b000,  3, 1'b0, 2'd0, 0, 8'd0,   16'd0, 4'h0};
    vecs[1]  = '{3'b100, 10, 1'b0, 2'd1, 0, 8'd0,   16'd0, 4'h0};
    vecs[2]  = '{3'b010,  3, 1'b0, 2'd2, 1, 8'd10,  16'd0, 4'h0};
    vecs[3]  = '{3'b001,  3, 1'b0, 2'd3, 1, 8'd3,   16'd0, 4'h0};
    vecs[4]  = '{3'b100, 10, 1'b0, 2'd1, 1, 8'd3,   16'd1, 4'h0};
    vecs[5]  = '{3'b010,  1, 1'b0, 2'd1, 0, 8'd3,   16'd1, 4'h0};
    vecs[6]  = '{3'b001,  3, 1'b0, 2'd3, 2, 8'd1,   16'd1, 4'h4};
    vecs[7]  = '{3'b100, 10, 1'b0, 2'd1, 1, 8'd3,   16'd2, 4'h4};
    vecs[8]  = '{3'b010,  3, 1'b1, 2'd2, 1, 8'd10,  16'd2, 4'h0};
    vecs[9]  = '{3'b001,  3, 1'b0, 2'd3, 1, 8'd3,   16'd2, 4'h0};
    vecs[10] = '{3'b100, 81, 1'b0, 2'd1, 1, 8'd3,   16'd3, 4'h0};
    vecs[11] = '{3'b100,  1, 1'b0, 2'd1, 0, 8'd3,   16'd3, 4'h8};
    vecs[12] = '{3'b100, 18, 1'b0, 2'd1, 0, 8'd3,   16'd3, 4'h8};
    vecs[13] = '{3'b010,  3, 1'b0, 2'd2, 1, 8'd100, 16'd3, 4'h8};
    vecs[14] = '{3'b001,  3, 1'b0, 2'd3, 1, 8'd3,   16'd3, 4'h8};
    vecs[15] = '{3'b100,  5, 1'b1, 2'd1, 1, 8'd3,   16'd4, 4'h0};
    vecs[16] = '{3'b001,  4, 1'b0, 2'd3, 0, 8'd3,   16'd4, 4'h2};
    vecs[17] = '{3'b100,  5, 1'b1, 2'd1, 1, 8'd4,   16'd5, 4'h0};
    vecs[18] = '{3'b110,  2, 1'b0, 2'd0, 0, 8'd4,   16'd5, 4'h1};
    vecs[19] = '{3'b010,  3, 1'b0, 2'd2, 0, 8'd4,   16'd5, 4'h1};
    vecs[20] = '{3'b001,  3, 1'b0, 2'd3, 1, 8'd3,   16'd5, 4'h1};
    vecs[21] = '{3'b011,  2, 1'b1, 2'd0, 0, 8'd3,   16'd5, 4'h1};
    vecs[22] = '{3'b000,  3, 1'b1, 2'd0, 0, 8'd3,   16'd5, 4'h0};
    vecs[23] = '{3'b111,  1, 1'b0, 2'd0, 0, 8'd3,   16'd5, 4'h0};
    vecs[24] = '{3'b000,  3, 1'b0, 2'd0, 0, 8'd3,   16'd5, 4'h1};

    #12;
    chk("reset phase",    32'(bus.phase),      32'd0);
    chk("reset done",     32'(bus.phase_done), 32'd0);
    chk("reset last_len", 32'(bus.last_len),   32'd0);
    chk("reset cycles",   32'(bus.cycles),     32'd0);
    chk("reset err",      32'(bus.err),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].leds, vecs[i].hold, vecs[i].clr);
      chk($sformatf("step%0d phase", i),    32'(bus.phase),  32'(vecs[i].ph));
      chk($sformatf("step%0d done", i),     32'(done_cnt),   32'(vecs[i].done));
      chk($sformatf("step%0d last_len", i), 32'(bus.last_len), 32'(vecs[i].len));
      chk($sformatf("step%0d cycles", i),   32'(bus.cycles), 32'(vecs[i].cyc));
      chk($sformatf("step%0d err", i),      32'(bus.err),    32'(vecs[i].err));
      if (vecs[i].done > 0)
        chk($sformatf("step%0d pulse_len", i), 32'(len_seen), 32'(vecs[i].len));
    end

    // Two-cycle latency from lamp to phase.
    step(3'b100, 1, 1'b1);
    chk("lat edge1 phase", 32'(bus.phase), 32'd0);
    step(3'b100, 1, 1'b0);
    chk("lat edge2 phase", 32'(bus.phase), 32'd1);
    chk("lat err", 32'(bus.err), 32'd0);
    step(3'b100, 3, 1'b0);
    step(3'b010, 3, 1'b0);
    step(3'b001, 2, 1'b0);
    chk("pre-reset last_len", 32'(bus.last_len), 32'd3);
    chk("pre-reset phase", 32'(bus.phase), 32'd3);

    // Asynchronous reset in the middle of red.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async phase",    32'(bus.phase),      32'd0);
    chk("async last_len", 32'(bus.last_len),   32'd0);
    chk("async cycles",   32'(bus.cycles),     32'd0);
    chk("async err",      32'(bus.err),        32'd0);
    chk("async done",     32'(bus.phase_done), 32'd0);
    bus.leds = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b000, 3, 1'b0);
    step(3'b100, 5, 1'b0);
    chk("post-reset phase", 32'(bus.phase), 32'd1);
    chk("post-reset err",   32'(bus.err),   32'd0);
    step(3'b010, 3, 1'b0);
    chk("post-reset done",  32'(done_cnt),     32'd1);
    chk("post-reset len",   32'(bus.last_len), 32'd5);
    chk("post-reset cyc",   32'(bus.cycles),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
